// File: rtl/vid_mem_arbiter.sv
// Frame-buffer arbiter: display reads take priority, camera writes are buffered
// in a small FIFO and drained into idle slots, with one forced write when it fills.
module vid_mem_arbiter #(
  parameter  int ADDR_W   = 19,
  parameter  int DATA_W   = 16,
  parameter  int MEM_LAT  = 1,
  parameter  int WF_DEPTH = 4,
  localparam int PTR_W    = $clog2(WF_DEPTH),
  localparam int LVL_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_miss,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LVL_W-1:0]  wf_level
);

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2,
    GNT_FORCE = 2'd3
  } gnt_t;

  gnt_t              gnt;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] fifo_addr [WF_DEPTH];
  logic [DATA_W-1:0] fifo_data [WF_DEPTH];
  logic [MEM_LAT:0]  rd_pipe;

  // Arbitration on the current-cycle state, a full FIFO beating the display
  always_comb begin
    gnt = GNT_IDLE;
    if (wf_level == LVL_W'(WF_DEPTH)) begin
      gnt = GNT_FORCE;
    end else if (rd_req) begin
      gnt = GNT_READ;
    end else if (wf_level != '0) begin
      gnt = GNT_WRITE;
    end else begin
      gnt = GNT_IDLE;
    end
  end

  assign rd_gnt   = (gnt == GNT_READ);
  assign pop      = (gnt == GNT_WRITE) || (gnt == GNT_FORCE);
  assign wr_ready = (wf_level < LVL_W'(WF_DEPTH));
  // flush wins over a coincident push, so the dropped word never lands
  assign push     = wr_valid && wr_ready && !flush;

  // FIFO storage; contents are don't-care until the count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wf_level <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wf_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   wf_level <= wf_level + LVL_W'(1);
        2'b01:   wf_level <= wf_level - LVL_W'(1);
        default: wf_level <= wf_level;
      endcase
    end
  end

  // Memory command register; address and write data hold across idle cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_miss   <= 1'b0;
    end else begin
      mem_en  <= (gnt != GNT_IDLE);
      rd_miss <= (gnt == GNT_FORCE) && rd_req;
      case (gnt)
        GNT_READ: begin
          mem_we   <= 1'b0;
          mem_addr <= rd_addr;
        end
        GNT_WRITE, GNT_FORCE: begin
          mem_we    <= 1'b1;
          mem_addr  <= fifo_addr[rd_ptr];
          mem_wdata <= fifo_data[rd_ptr];
        end
        default: begin
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // In-flight read tracker: bit k set during the (k+1)th cycle after a read grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pipe  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe  <= {rd_pipe[MEM_LAT-1:0], rd_gnt};
      rd_valid <= rd_pipe[MEM_LAT];
      if (rd_pipe[MEM_LAT]) begin
        rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Randomised bench for vid_mem_arbiter: a queue-based reference model predicts
// grants, memory commands, read returns and FIFO level cycle by cycle.
module tb_vid_mem_arbiter;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 16;
  localparam int MEM_LAT  = 1;
  localparam int WF_DEPTH = 4;
  localparam int LVL_W    = $clog2(WF_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_miss;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              flush = 1'b0;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [LVL_W-1:0]  wf_level;

  vid_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .WF_DEPTH(WF_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_miss(rd_miss),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wf_level(wf_level)
  );

  always #5 clk = ~clk;

  // Single-cycle-latency memory: a read of addr returns addr + 0x100
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[DATA_W-1:0] + 16'h0100;
  end

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct { int due; logic [DATA_W-1:0] d; } rd_t;

  wr_t               q[$];
  rd_t               pend[$];
  int                edge_n = 0;
  int                n_vec = 0;
  int                n_err = 0;
  bit                exp_en = 1'b0;
  bit                exp_we = 1'b0;
  bit                exp_miss = 1'b0;
  bit                last_gr = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pend.delete();
    exp_en = 1'b0; exp_we = 1'b0; exp_miss = 1'b0; last_gr = 1'b0;
    exp_addr = '0; exp_wdata = '0;
  endtask

  // One clock cycle: check combinational outputs, advance model, check registers
  task automatic step();
    int lvl;
    bit force_w, gr, gw, exp_v;
    logic [DATA_W-1:0] exp_d;
    #1;
    lvl     = q.size();
    force_w = (lvl == WF_DEPTH);
    gr      = rd_req && !force_w;
    gw      = force_w || (!rd_req && lvl > 0);
    check_val("rd_gnt", rd_gnt, gr);
    check_val("wr_ready", wr_ready, lvl < WF_DEPTH);
    @(posedge clk);
    edge_n++;
    exp_miss = force_w && rd_req;
    exp_en   = gr || gw;
    exp_d    = '0;
    if (gr) begin
      exp_we   = 1'b0;
      exp_addr = rd_addr;
      pend.push_back('{edge_n + 1 + MEM_LAT, rd_addr[DATA_W-1:0] + 16'h0100});
    end else if (gw) begin
      exp_we    = 1'b1;
      exp_addr  = q[0].a;
      exp_wdata = q[0].d;
      void'(q.pop_front());
    end else begin
      exp_we = 1'b0;
    end
    if (flush) q.delete();
    else if (wr_valid && lvl < WF_DEPTH) q.push_back('{wr_addr, wr_data});
    last_gr = gr;
    exp_v = 1'b0;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      exp_v = 1'b1;
      exp_d = pend[0].d;
      void'(pend.pop_front());
    end
    #1;
    check_val("mem_en", mem_en, exp_en);
    if (exp_en) check_val("mem_we", mem_we, exp_we);
    check_val("mem_addr", mem_addr, exp_addr);
    if (exp_en && exp_we) check_val("mem_wdata", mem_wdata, exp_wdata);
    check_val("rd_miss", rd_miss, exp_miss);
    check_val("rd_valid", rd_valid, exp_v);
    if (exp_v) check_val("rd_data", rd_data, exp_d);
    check_val("wf_level", wf_level, q.size());
    @(negedge clk);
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must clear at once
  task automatic reset_phase();
    rd_req = 1'b0; wr_valid = 1'b0; flush = 1'b0;
    #3 reset = 1'b0;
    #1;
    check_val("rst_rd_valid", rd_valid, 1'b0);
    check_val("rst_rd_data", rd_data, 16'h0000);
    check_val("rst_rd_miss", rd_miss, 1'b0);
    check_val("rst_mem_en", mem_en, 1'b0);
    check_val("rst_mem_we", mem_we, 1'b0);
    check_val("rst_mem_addr", mem_addr, 19'h0);
    check_val("rst_mem_wdata", mem_wdata, 16'h0000);
    check_val("rst_wf_level", wf_level, 3'd0);
    check_val("rst_wr_ready", wr_ready, 1'b1);
    check_val("rst_rd_gnt", rd_gnt, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    reset_phase();

    // Back-to-back reads at 10, 11, 12
    rd_req = 1'b1; rd_addr = 19'd10; step();
    rd_addr = 19'd11; step();
    rd_addr = 19'd12; step();
    rd_req = 1'b0; repeat (4) step();

    // Two writes drained with the display idle
    wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 16'hAAAA; step();
    wr_addr = 19'd6; wr_data = 16'hBBBB; step();
    wr_valid = 1'b0; repeat (3) step();

    // Display hogging the memory until the FIFO fills and forces writes
    rd_req = 1'b1; rd_addr = 19'd100;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_addr = 19'h40000 + 19'(i); wr_data = 16'(i * 16'h0111);
      step();
      if (last_gr) rd_addr = rd_addr + 19'd1;
    end
    wr_valid = 1'b0;
    repeat (4) begin
      step();
      if (last_gr) rd_addr = rd_addr + 19'd1;
    end
    rd_req = 1'b0; repeat (6) step();

    // Flush at level 3 together with a push
    rd_req = 1'b1; rd_addr = 19'd200;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 19'h50000 + 19'(i); wr_data = 16'hC000 + 16'(i);
      step();
      if (last_gr) rd_addr = rd_addr + 19'd1;
    end
    flush = 1'b1; wr_data = 16'hDEAD; step();
    flush = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; repeat (4) step();

    // Reset with two reads in flight
    rd_req = 1'b1; rd_addr = 19'd300; step();
    rd_addr = 19'd301; step();
    reset_phase();
    repeat (5) step();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      if (!(rd_req && !last_gr)) begin
        rd_req  = ($urandom_range(0, 99) < 60);
        rd_addr = 19'($urandom_range(0, 4095));
      end
      wr_valid = ($urandom_range(0, 99) < 50);
      wr_addr  = 19'h40000 + 19'($urandom_range(0, 4095));
      wr_data  = 16'($urandom_range(0, 65535));
      flush    = ($urandom_range(0, 99) < 3);
      step();
    end
    rd_req = 1'b0; wr_valid = 1'b0; flush = 1'b0;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
